// File: rtl/ula_pkg.sv
// Shared definitions for the ULA front-end: widths, opcode encodings
// and the sequencer state enumeration.
package ula_pkg;

    // Default datapath widths
    localparam int ULA_DATA_W = 8;
    localparam int ULA_OP_W   = 4;
    localparam int ULA_RES_W  = 16;

    // Settle counter width; covers EXEC_CYCLES up to 15
    localparam int ULA_CNT_W  = 4;

    // ULA selector encodings (the sequencer passes them through untouched)
    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_MUL  = 4'b0010;
    localparam logic [3:0] OP_DIV  = 4'b0011;
    localparam logic [3:0] OP_SHL  = 4'b0100;
    localparam logic [3:0] OP_SHR  = 4'b0101;
    localparam logic [3:0] OP_ROL  = 4'b0110;
    localparam logic [3:0] OP_ROR  = 4'b0111;
    localparam logic [3:0] OP_AND  = 4'b1000;
    localparam logic [3:0] OP_OR   = 4'b1001;
    localparam logic [3:0] OP_XOR  = 4'b1010;
    localparam logic [3:0] OP_NOR  = 4'b1011;
    localparam logic [3:0] OP_NAND = 4'b1100;
    localparam logic [3:0] OP_XNOR = 4'b1101;
    localparam logic [3:0] OP_GT   = 4'b1110;
    localparam logic [3:0] OP_EQ   = 4'b1111;

    // Sequencer states
    typedef enum logic [2:0] {
        GET_OP = 3'd0,
        GET_A  = 3'd1,
        GET_B  = 3'd2,
        EXEC   = 3'd3,
        HOLD   = 3'd4
    } seq_state_t;

endpackage

// File: rtl/ula_sequencer.sv
// Front-end sequencer for the 8-bit ULA. Collects opcode, A and B bytes,
// drives the ULA inputs from registers, waits EXEC_CYCLES edges for the
// combinational result to settle, then holds the captured result until
// the consumer takes it.
//
// Handshakes: a transfer happens on a rising edge where valid && ready.
// in_ready and res_valid are pure state decodes and never depend on the
// partner's valid/ready. flush overrides any transfer on the same edge.
module ula_sequencer
    import ula_pkg::*;
#(
    parameter int DATA_W      = ULA_DATA_W,
    parameter int OP_W        = ULA_OP_W,
    parameter int RES_W       = ULA_RES_W,
    parameter int EXEC_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              flush,
    output logic [DATA_W-1:0] ula_a,
    output logic [DATA_W-1:0] ula_b,
    output logic [OP_W-1:0]   ula_sel,
    input  logic [RES_W-1:0]  ula_s,
    output logic [RES_W-1:0]  res_data,
    output logic [OP_W-1:0]   res_op,
    output logic              res_zero,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [7:0]        op_count
);

    // Counter value at which the ULA output is considered settled
    localparam logic [ULA_CNT_W-1:0] CNT_LAST = ULA_CNT_W'(EXEC_CYCLES - 1);

    seq_state_t            state_q, state_d;
    logic [ULA_CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0]     a_q, a_d;
    logic [DATA_W-1:0]     b_q, b_d;
    logic [OP_W-1:0]       sel_q, sel_d;
    logic [RES_W-1:0]      res_data_q, res_data_d;
    logic [OP_W-1:0]       res_op_q, res_op_d;
    logic                  res_zero_q, res_zero_d;
    logic [7:0]            op_count_q, op_count_d;
    logic                  accept;

    // Handshake decodes depend only on state
    assign in_ready  = (state_q == GET_OP) || (state_q == GET_A) || (state_q == GET_B);
    assign res_valid = (state_q == HOLD);
    assign accept    = in_valid && in_ready;

    assign ula_a    = a_q;
    assign ula_b    = b_q;
    assign ula_sel  = sel_q;
    assign res_data = res_data_q;
    assign res_op   = res_op_q;
    assign res_zero = res_zero_q;
    assign op_count = op_count_q;

    // Next-state and register-update logic; flush overrides everything
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        a_d        = a_q;
        b_d        = b_q;
        sel_d      = sel_q;
        res_data_d = res_data_q;
        res_op_d   = res_op_q;
        res_zero_d = res_zero_q;
        op_count_d = op_count_q;

        case (state_q)
            GET_OP: begin
                if (accept) begin
                    sel_d   = in_data[OP_W-1:0];
                    state_d = GET_A;
                end
            end
            GET_A: begin
                if (accept) begin
                    a_d     = in_data;
                    state_d = GET_B;
                end
            end
            GET_B: begin
                if (accept) begin
                    b_d     = in_data;
                    cnt_d   = '0;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (cnt_q == CNT_LAST) begin
                    res_data_d = ula_s;
                    res_op_d   = sel_q;
                    res_zero_d = (ula_s == '0);
                    state_d    = HOLD;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HOLD: begin
                if (res_ready) begin
                    op_count_d = op_count_q + 8'd1;
                    state_d    = GET_OP;
                end
            end
            default: state_d = GET_OP;
        endcase

        // Abort: drop any byte or result taken this edge, keep old values
        if (flush) begin
            state_d    = GET_OP;
            a_d        = a_q;
            b_d        = b_q;
            sel_d      = sel_q;
            res_data_d = res_data_q;
            res_op_d   = res_op_q;
            res_zero_d = res_zero_q;
            op_count_d = op_count_q;
        end
    end

    // State and datapath registers with asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= GET_OP;
            cnt_q      <= '0;
            a_q        <= '0;
            b_q        <= '0;
            sel_q      <= '0;
            res_data_q <= '0;
            res_op_q   <= '0;
            res_zero_q <= 1'b1;
            op_count_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            a_q        <= a_d;
            b_q        <= b_d;
            sel_q      <= sel_d;
            res_data_q <= res_data_d;
            res_op_q   <= res_op_d;
            res_zero_q <= res_zero_d;
            op_count_q <= op_count_d;
        end
    end

endmodule

// File: tb/tb_ula_sequencer.sv
// Bench for ula_sequencer: a behavioural ULA closes the loop on ula_s,
// a table of commands with hand-computed results is replayed, and short
// directed sequences cover result backpressure, flush, reset in HOLD and
// a longer settle time on a second instance.
module tb_ula_sequencer;
    import ula_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    // Instance with EXEC_CYCLES = 1
    logic [7:0]  in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        flush = 1'b0;
    logic [7:0]  ula_a, ula_b;
    logic [3:0]  ula_sel;
    logic [15:0] ula_s;
    logic [15:0] res_data;
    logic [3:0]  res_op;
    logic        res_zero, res_valid;
    logic        res_ready = 1'b1;
    logic [7:0]  op_count;

    // Instance with EXEC_CYCLES = 3
    logic [7:0]  in_data3 = '0;
    logic        in_valid3 = 1'b0;
    logic        in_ready3;
    logic        flush3 = 1'b0;
    logic [7:0]  ula_a3, ula_b3;
    logic [3:0]  ula_sel3;
    logic [15:0] ula_s3;
    logic [15:0] res_data3;
    logic [3:0]  res_op3;
    logic        res_zero3, res_valid3;
    logic        res_ready3 = 1'b1;
    logic [7:0]  op_count3;

    int pass_cnt = 0;
    int total_cnt = 0;
    logic [7:0] exp_count = 8'd0;

    // Behavioural ULA
    function automatic logic [15:0] ula_model(input logic [7:0] a, input logic [7:0] b,
                                              input logic [3:0] sel);
        logic [15:0] wa, wb;
        wa = {8'h00, a};
        wb = {8'h00, b};
        case (sel)
            OP_ADD:  return wa + wb;
            OP_SUB:  return wa - wb;
            OP_MUL:  return wa * wb;
            OP_DIV:  return (b == 8'h00) ? 16'hFFFF : wa / wb;
            OP_SHL:  return {8'h00, a << b[2:0]};
            OP_SHR:  return {8'h00, a >> b[2:0]};
            OP_ROL:  return {8'h00, (a << b[2:0]) | (a >> (4'd8 - {1'b0, b[2:0]}))};
            OP_ROR:  return {8'h00, (a >> b[2:0]) | (a << (4'd8 - {1'b0, b[2:0]}))};
            OP_AND:  return {8'h00, a & b};
            OP_OR:   return {8'h00, a | b};
            OP_XOR:  return {8'h00, a ^ b};
            OP_NOR:  return {8'h00, ~(a | b)};
            OP_NAND: return {8'h00, ~(a & b)};
            OP_XNOR: return {8'h00, ~(a ^ b)};
            OP_GT:   return {15'd0, a > b};
            default: return {15'd0, a == b};
        endcase
    endfunction

    assign ula_s  = ula_model(ula_a, ula_b, ula_sel);
    assign ula_s3 = ula_model(ula_a3, ula_b3, ula_sel3);

    ula_sequencer #(.DATA_W(8), .OP_W(4), .RES_W(16), .EXEC_CYCLES(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
        .ula_a(ula_a), .ula_b(ula_b), .ula_sel(ula_sel), .ula_s(ula_s),
        .res_data(res_data), .res_op(res_op), .res_zero(res_zero),
        .res_valid(res_valid), .res_ready(res_ready), .op_count(op_count)
    );

    ula_sequencer #(.DATA_W(8), .OP_W(4), .RES_W(16), .EXEC_CYCLES(3)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data3), .in_valid(in_valid3), .in_ready(in_ready3), .flush(flush3),
        .ula_a(ula_a3), .ula_b(ula_b3), .ula_sel(ula_sel3), .ula_s(ula_s3),
        .res_data(res_data3), .res_op(res_op3), .res_zero(res_zero3),
        .res_valid(res_valid3), .res_ready(res_ready3), .op_count(op_count3)
    );

    // Clock
    always #5 clk = ~clk;

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Advance one edge; inputs are driven and outputs sampled 1 time unit later
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one byte to the EXEC_CYCLES=1 instance and take it in one edge
    task automatic send_byte(input logic [7:0] d);
        check("in_ready before byte", in_ready, 1'b1);
        in_data  = d;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    typedef struct {
        logic [7:0]  op;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] exp_res;
        logic [3:0]  exp_op;
        logic        exp_zero;
    } vec_t;

    vec_t vecs[7];

    initial begin
        vecs[0] = '{8'h00, 8'h18, 8'h1F, 16'h0037, 4'h0, 1'b0}; // ADD
        vecs[1] = '{8'h0F, 8'h5A, 8'h5A, 16'h0001, 4'hF, 1'b0}; // EQ
        vecs[2] = '{8'h08, 8'h0F, 8'hF0, 16'h0000, 4'h8, 1'b1}; // AND
        vecs[3] = '{8'h01, 8'h20, 8'h05, 16'h001B, 4'h1, 1'b0}; // SUB
        vecs[4] = '{8'h02, 8'h10, 8'h10, 16'h0100, 4'h2, 1'b0}; // MUL
        vecs[5] = '{8'h0A, 8'hFF, 8'h0F, 16'h00F0, 4'hA, 1'b0}; // XOR
        vecs[6] = '{8'hF1, 8'h05, 8'h05, 16'h0000, 4'h1, 1'b1}; // SUB, upper opcode bits ignored

        // Reset
        rst_n = 1'b0;
        #22;
        check("reset ula_a", ula_a, 8'h00);
        check("reset ula_b", ula_b, 8'h00);
        check("reset ula_sel", ula_sel, 4'h0);
        check("reset res_data", res_data, 16'h0000);
        check("reset res_op", res_op, 4'h0);
        check("reset res_zero", res_zero, 1'b1);
        check("reset res_valid", res_valid, 1'b0);
        check("reset in_ready", in_ready, 1'b1);
        check("reset op_count", op_count, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Table of commands with res_ready held high
        res_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            send_byte(vecs[i].op);
            send_byte(vecs[i].a);
            send_byte(vecs[i].b);
            check("exec res_valid low", res_valid, 1'b0);
            check("exec in_ready low", in_ready, 1'b0);
            tick();
            check("hold res_valid", res_valid, 1'b1);
            check("vec res_data", res_data, vecs[i].exp_res);
            check("vec res_op", res_op, vecs[i].exp_op);
            check("vec res_zero", res_zero, vecs[i].exp_zero);
            tick();
            exp_count = exp_count + 8'd1;
            check("handoff res_valid low", res_valid, 1'b0);
            check("vec op_count", op_count, exp_count);
            // res_ready high while idle must not count
            tick();
            check("idle op_count", op_count, exp_count);
        end

        // Reset during HOLD with op_count = 7
        res_ready = 1'b0;
        send_byte(8'h01);
        send_byte(8'h09);
        send_byte(8'h03);
        tick();
        check("pre-reset res_valid", res_valid, 1'b1);
        check("pre-reset res_data", res_data, 16'h0006);
        check("pre-reset op_count", op_count, 8'd7);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid reset res_valid", res_valid, 1'b0);
        check("mid reset op_count", op_count, 8'h00);
        check("mid reset in_ready", in_ready, 1'b1);
        check("mid reset ula_a", ula_a, 8'h00);
        check("mid reset ula_b", ula_b, 8'h00);
        check("mid reset ula_sel", ula_sel, 4'h0);
        check("mid reset res_data", res_data, 16'h0000);
        check("mid reset res_zero", res_zero, 1'b1);
        exp_count = 8'd0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Result backpressure: res_ready low for 5 cycles in HOLD
        res_ready = 1'b0;
        send_byte(8'h00);
        send_byte(8'hFF);
        send_byte(8'hFB);
        tick();
        for (int c = 0; c < 5; c++) begin
            check("stall res_valid", res_valid, 1'b1);
            check("stall res_data", res_data, 16'h01FA);
            check("stall in_ready", in_ready, 1'b0);
            check("stall op_count", op_count, exp_count);
            tick();
        end
        res_ready = 1'b1;
        tick();
        exp_count = exp_count + 8'd1;
        check("stall handoff res_valid", res_valid, 1'b0);
        check("stall handoff op_count", op_count, exp_count);

        // Flush in GET_B on the same edge as a valid B byte
        send_byte(8'h00);
        send_byte(8'h11);
        in_data  = 8'h22;
        in_valid = 1'b1;
        flush    = 1'b1;
        tick();
        in_valid = 1'b0;
        flush    = 1'b0;
        check("flush in_ready", in_ready, 1'b1);
        check("flush ula_b kept", ula_b, 8'hFB);
        check("flush ula_a kept", ula_a, 8'h11);
        for (int c = 0; c < 3; c++) begin
            check("flush res_valid", res_valid, 1'b0);
            tick();
        end
        check("flush op_count", op_count, exp_count);
        send_byte(8'h00);
        send_byte(8'h01);
        send_byte(8'h02);
        tick();
        check("post-flush res_valid", res_valid, 1'b1);
        check("post-flush res_data", res_data, 16'h0003);
        tick();
        exp_count = exp_count + 8'd1;
        check("post-flush op_count", op_count, exp_count);

        // Flush in HOLD drops the pending result without counting it
        res_ready = 1'b0;
        send_byte(8'h00);
        send_byte(8'h40);
        send_byte(8'h02);
        tick();
        check("hold flush res_valid before", res_valid, 1'b1);
        flush     = 1'b1;
        res_ready = 1'b1;
        tick();
        flush = 1'b0;
        check("hold flush res_valid", res_valid, 1'b0);
        check("hold flush op_count", op_count, exp_count);
        check("hold flush res_data kept", res_data, 16'h0042);

        // EXEC_CYCLES = 3 instance: B accepted at edge k, result at k+3
        in_data3 = 8'h00; in_valid3 = 1'b1; tick();
        in_data3 = 8'h03; tick();
        in_data3 = 8'h04; tick();
        in_valid3 = 1'b0;
        check("e3 k res_valid", res_valid3, 1'b0);
        check("e3 k ula_b", ula_b3, 8'h04);
        tick();
        check("e3 k+1 res_valid", res_valid3, 1'b0);
        check("e3 k+1 ula_b", ula_b3, 8'h04);
        tick();
        check("e3 k+2 res_valid", res_valid3, 1'b0);
        check("e3 k+2 ula_b", ula_b3, 8'h04);
        res_ready3 = 1'b0;
        tick();
        check("e3 k+3 res_valid", res_valid3, 1'b1);
        check("e3 res_data", res_data3, 16'h0007);
        res_ready3 = 1'b1;
        tick();
        check("e3 handoff res_valid", res_valid3, 1'b0);
        check("e3 op_count", op_count3, 8'd1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
